obs_scroll_gen: RTL



---
 rtl/obs_scroll_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/obs_scroll_gen.sv
// obs_scroll_gen: obstacle generator feeding the 7-segment display driver.
// Divides clk into a world-dependent scroll tick. Each tick shifts the three
// obstacle digits toward the exit and loads a new entry pattern drawn from an
// 8-bit Galois LFSR. Any bonus glyph on screen is blanked when the player
// takes it.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   en             game running; low freezes the divider, display and LFSR
//   clear_i        synchronous restart to the reset state
//   mundo_i[1:0]   world level; the scroll period is DIV_BASE >> mundo_i
//   bono_tomado_i  one-cycle pulse, the player took the bonus
//   display_obs    {exit[20:14], middle[13:7], entry[6:0]}, segment a = bit 0
//   obs_counter    number of non-blank digits in display_obs
//   bono_activo_o  a bonus glyph is present in some digit
//   tick_o         one-cycle scroll strobe (combinational)
module obs_scroll_gen #(
  parameter logic [29:0] DIV_BASE  = 30'd27000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear_i,
  input  logic [1:0]  mundo_i,
  input  logic        bono_tomado_i,
  output logic [20:0] display_obs,
  output logic [1:0]  obs_counter,
  output logic        bono_activo_o,
  output logic        tick_o
);

  localparam int unsigned DIGIT_W   = 7;
  localparam int unsigned NUM_DIGIT = 3;
  localparam logic [6:0]  GLYPH_BLANK = 7'h00;
  localparam logic [6:0]  GLYPH_LOW   = 7'h08;
  localparam logic [6:0]  GLYPH_HIGH  = 7'h01;
  localparam logic [6:0]  GLYPH_BONUS = 7'h40;
  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  logic [29:0] r_div;
  logic [7:0]  r_lfsr;

  logic [29:0] w_limit;
  logic        w_tick;
  logic        w_bonus_shifted;
  logic [6:0]  w_new_digit;
  logic [29:0] w_div_nxt;
  logic [7:0]  w_lfsr_nxt;
  logic [20:0] w_disp_nxt;
  logic [1:0]  w_cnt_nxt;
  logic        w_bono_nxt;

  function automatic logic [7:0] lfsr_advance(input logic [7:0] v);
    lfsr_advance = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Scroll tick; >= (not ==) so lowering the limit mid-count can never overrun
  assign w_limit = DIV_BASE >> mundo_i;
  assign w_tick  = en & (r_div >= (w_limit - 30'd1));
  assign tick_o  = w_tick;

  // Only the digits that survive the shift can block a new bonus
  assign w_bonus_shifted = (display_obs[6:0] == GLYPH_BONUS) ||
                           (display_obs[13:7] == GLYPH_BONUS);

  // Entry pattern from the pre-advance LFSR
  always_comb begin
    w_new_digit = GLYPH_BLANK;
    unique case (r_lfsr[1:0])
      2'b00: w_new_digit = GLYPH_BLANK;
      2'b01: w_new_digit = GLYPH_LOW;
      2'b10: w_new_digit = GLYPH_HIGH;
      2'b11: w_new_digit = w_bonus_shifted ? GLYPH_BLANK : GLYPH_BONUS;
      default: w_new_digit = GLYPH_BLANK;
    endcase
  end

  // Next divider, LFSR and display; bonus take is applied after the shift
  always_comb begin
    w_div_nxt  = r_div;
    w_lfsr_nxt = r_lfsr;
    w_disp_nxt = display_obs;
    w_cnt_nxt  = 2'd0;
    w_bono_nxt = 1'b0;

    if (en) begin
      w_div_nxt = w_tick ? 30'd0 : (r_div + 30'd1);
    end

    if (w_tick) begin
      w_disp_nxt = {display_obs[13:0], w_new_digit};
      w_lfsr_nxt = lfsr_advance(r_lfsr);
    end

    if (bono_tomado_i) begin
      for (int i = 0; i < NUM_DIGIT; i++) begin
        if (w_disp_nxt[i*DIGIT_W +: DIGIT_W] == GLYPH_BONUS) begin
          w_disp_nxt[i*DIGIT_W +: DIGIT_W] = GLYPH_BLANK;
        end
      end
    end

    for (int i = 0; i < NUM_DIGIT; i++) begin
      if (w_disp_nxt[i*DIGIT_W +: DIGIT_W] != GLYPH_BLANK) begin
        w_cnt_nxt = w_cnt_nxt + 2'd1;
      end
      if (w_disp_nxt[i*DIGIT_W +: DIGIT_W] == GLYPH_BONUS) begin
        w_bono_nxt = 1'b1;
      end
    end
  end

  // State and registered outputs; clear_i overrides tick and bonus take
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= 30'd0;
      r_lfsr        <= LFSR_SEED;
      display_obs   <= 21'd0;
      obs_counter   <= 2'd0;
      bono_activo_o <= 1'b0;
    end else if (clear_i) begin
      r_div         <= 30'd0;
      r_lfsr        <= LFSR_SEED;
      display_obs   <= 21'd0;
      obs_counter   <= 2'd0;
      bono_activo_o <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_lfsr        <= w_lfsr_nxt;
      display_obs   <= w_disp_nxt;
      obs_counter   <= w_cnt_nxt;
      bono_activo_o <= w_bono_nxt;
    end
  end

endmodule
